// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared widths and constants for the instruction-fetch stage.
//   InstAddrBus / InstBus : default address and instruction widths
//   RstEnable             : level of the active-low reset when asserted
//   RESET_PC_DEF          : default first fetch address
//   NOP_INST              : canonical NOP encoding (addi x0,x0,0)
package if_fetch_pkg;
  localparam int          InstAddrBus  = 32;
  localparam int          InstBus      = 32;
  localparam logic        RstEnable    = 1'b0;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO used for the pending-PC queue and the
// instruction buffer.
//   clk, rst (async active-low), flush (clears contents, wins over push/pop)
//   push/din  : write one entry
//   pop       : drop the head entry
//   dout      : head entry (undefined when empty)
//   count     : entries held, empty : count==0
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import if_fetch_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign count = cnt;
  assign empty = (cnt == '0);
endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Generates the PC, requests instruction
// memory over req/gnt/rvalid, and buffers returned instructions for IF/ID.
//   clk, rst (async active-low)
//   stall_i                : hold the head instruction
//   branch_flag_i/target_i : redirect fetch, flush everything in flight
//   imem_req/addr/gnt      : request side, imem_rvalid/rdata : in-order responses
//   if_pc/if_inst/if_valid : head of the instruction buffer (zero when empty)
// Optional: define IF_FETCH_PERF_EN to add perf_fetch_cnt / perf_stall_cnt.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                RESET_PC_W = InstAddrBus,
  parameter int                ADDR_W     = RESET_PC_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF),
  parameter int                DEPTH      = 2,
  parameter int                INST_W     = InstBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_valid
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]        fetch_pc;
  logic [CW-1:0]            outstanding, discard, outstanding_nxt;
  logic [CW-1:0]            buf_cnt, pend_cnt;
  logic                     buf_empty, pend_empty;
  logic [ADDR_W-1:0]        pend_pc;
  logic [ADDR_W+INST_W-1:0] buf_head;
  logic                     grant, resp, drop, buf_push, buf_pop;

  // Credits cover both in-flight requests (including ones to be discarded)
  // and buffered instructions, so neither FIFO can overflow.
  assign imem_req  = (rst != RstEnable) && !branch_flag_i &&
                     ((outstanding + buf_cnt) < CW'(DEPTH));
  assign imem_addr = fetch_pc;

  assign grant    = imem_req && imem_gnt;
  assign resp     = imem_rvalid && (outstanding != '0);  // stray rvalids ignored
  assign drop     = (discard != '0);
  assign buf_push = resp && !drop && !branch_flag_i;
  assign buf_pop  = if_valid && !stall_i && !branch_flag_i;

  assign outstanding_nxt = outstanding + CW'(grant) - CW'(resp);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (branch_flag_i) begin
        fetch_pc <= {branch_target_i[ADDR_W-1:2], 2'b00};
        // Every request still outstanding after this cycle is stale.
        discard  <= outstanding_nxt;
      end else begin
        if (grant)        fetch_pc <= fetch_pc + ADDR_W'(4);
        if (resp && drop) discard  <= discard - CW'(1);
      end
    end
  end

  fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_pend (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_flag_i),
    .push  (grant),
    .din   (fetch_pc),
    .pop   (resp && !drop),
    .dout  (pend_pc),
    .count (pend_cnt),
    .empty (pend_empty)
  );

  fetch_fifo #(.W(ADDR_W+INST_W), .DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_flag_i),
    .push  (buf_push),
    .din   ({pend_pc, imem_rdata}),
    .pop   (buf_pop),
    .dout  (buf_head),
    .count (buf_cnt),
    .empty (buf_empty)
  );

  assign if_valid = !buf_empty;
  assign if_pc    = if_valid ? buf_head[ADDR_W+INST_W-1:INST_W] : '0;
  assign if_inst  = if_valid ? buf_head[INST_W-1:0] : '0;

`ifdef IF_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (buf_pop)             perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (if_valid && stall_i) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  a_rvalid_has_req: assert property (@(posedge clk) disable iff (rst == RstEnable)
    imem_rvalid |-> (outstanding != '0));
  // Non-discarded outstanding requests each own a pending-PC entry.
  a_pend_track: assert property (@(posedge clk) disable iff (rst == RstEnable)
    (pend_cnt + discard == outstanding) && (pend_empty == (pend_cnt == '0)));
endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0, rst = 1'b0;
  logic        stall_i = 1'b0, branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] if_pc, if_inst;
  logic        if_valid;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  if_fetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
`ifdef IF_FETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  mreq_t mem_q[$];   // memory side: granted requests awaiting response
  exp_t  exp_q[$];   // scoreboard: program-order instructions not yet consumed
  logic [31:0] model_pc;
  int compared = 0, mismatched = 0, pops = 0;
  bit mon_en = 0;

  // Stimulus knobs
  bit gnt_rand = 0, gnt_off = 0, force_stall = 0, br_on_rv = 0, rand_tgt = 0;
  int lat_min = 0, lat_max = 0, stall_pct = 0, br_pct = 0;
  logic [31:0] fixed_tgt = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus: memory answers in order once due, plus random control.
  task automatic step();
    @(posedge clk); #1;
    imem_gnt    = gnt_off ? 1'b0 : (gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    stall_i = force_stall || ($urandom_range(0, 99) < stall_pct);
    branch_flag_i = br_on_rv ? imem_rvalid : ($urandom_range(0, 99) < br_pct);
    if (br_on_rv && imem_rvalid) br_on_rv = 0;
    branch_target_i = rand_tgt ? 32'($urandom_range(0, 32'h3FFF)) : fixed_tgt;
  endtask

  // Monitor / scoreboard: predicts fetch addresses and the delivered stream
  // from the program-order rule (PC+4, restart at aligned target on branch).
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst) begin
      if (branch_flag_i) begin
        check("flush_no_req", imem_req, 0);
        exp_q.delete();
        model_pc = branch_target_i & ~32'h3;
      end else begin
        if (if_valid && !stall_i) begin
          pops++;
          if (exp_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL pop_unexpected: got pc %0h, expected no instruction", if_pc);
          end else begin
            e = exp_q.pop_front();
            check("if_pc", if_pc, e.pc);
            check("if_inst", if_inst, e.inst);
          end
        end
        if (!if_valid) check("idle_zero", {if_pc, if_inst}, 0);
        if (imem_req && imem_gnt) begin
          check("imem_addr", imem_addr, model_pc);
          exp_q.push_back('{model_pc, memf(model_pc)});
          model_pc += 32'd4;
        end
      end
      if (imem_req && imem_gnt)
        mem_q.push_back('{imem_addr, cyc + 1 + $urandom_range(lat_min, lat_max)});
    end
  end

  initial begin
    int n, p0;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_valid", if_valid, 0);
    check("rst_pc", if_pc, 0);
    check("rst_inst", if_inst, 0);
    check("rst_addr", imem_addr, 32'h0);

    // Streaming with gnt=1, rvalid one cycle after grant
    model_pc = 32'h0; mon_en = 1;
    @(posedge clk); #1; rst = 1'b1; imem_gnt = 1'b1;
    @(negedge clk); check("first_req", imem_req, 1);
    step(); @(negedge clk); check("lat_n1_valid", if_valid, 0);
    step(); @(negedge clk); check("lat_n2_valid", if_valid, 1); check("lat_n2_pc", if_pc, 32'h0);
    repeat (20) step();

    // Stall: credits fill to DEPTH, requests stop, head holds
    force_stall = 1;
    repeat (6) step();
    @(negedge clk);
    check("stall_req_off", imem_req, 0);
    check("stall_inflight", exp_q.size(), DEPTH);
    check("stall_head", if_pc, exp_q[0].pc);
    force_stall = 0;
    repeat (10) step();

    // Flush with two requests in flight, target 0x103
    gnt_off = 1; repeat (8) step(); gnt_off = 0;
    lat_min = 3; lat_max = 3;
    n = 0;
    do begin step(); @(negedge clk); n++; end while (mem_q.size() < 2 && n < 10);
    check("two_inflight", mem_q.size(), 2);
    fixed_tgt = 32'h103; br_pct = 100; step(); br_pct = 0;
    step(); @(negedge clk); check("redirect_addr", imem_addr, 32'h100);
    lat_min = 0; lat_max = 0;
    repeat (15) step();

    // rvalid coinciding with the flush cycle
    lat_min = 1; lat_max = 1; fixed_tgt = 32'h200; br_on_rv = 1;
    repeat (15) step();
    check("rv_flush_fired", br_on_rv, 0);

    // Randomised traffic
    gnt_rand = 1; lat_min = 0; lat_max = 3; stall_pct = 20; br_pct = 2; rand_tgt = 1;
    p0 = pops; n = 0;
    while (pops - p0 < 1000 && n < 20000) begin step(); n++; end
    check("random_pops", (pops - p0 >= 1000), 1);

    // Reset mid-stream with two outstanding
    gnt_rand = 0; stall_pct = 0; br_pct = 0; rand_tgt = 0; lat_min = 3; lat_max = 3;
    n = 0;
    do begin step(); @(negedge clk); n++; end while (mem_q.size() < 2 && n < 20);
    check("rst_two_inflight", mem_q.size(), 2);
    @(posedge clk); #1; rst = 1'b0; mon_en = 0; imem_rvalid = 1'b0; branch_flag_i = 1'b0;
    #1;
    check("mid_rst_valid", if_valid, 0);
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_pc", if_pc, 0);
    repeat (2) begin @(posedge clk); #1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; end
    mem_q.delete(); exp_q.delete(); model_pc = 32'h0; lat_min = 0; lat_max = 0;
    @(posedge clk); #1;
    imem_rvalid = 1'b0; imem_gnt = 1'b1; stall_i = 1'b0; rst = 1'b1; mon_en = 1;
    @(negedge clk); check("restart_addr", imem_addr, 32'h0);
    repeat (20) step();

    // Drain: everything granted must have been delivered
    gnt_off = 1; repeat (20) step();
    check("drain_scoreboard", exp_q.size(), 0);
    check("drain_memory", mem_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Generates the PC, issues requests to instruction memory over a req/gnt/rvalid handshake, and buffers the returned instructions.
- Presents {if_pc, if_inst, if_valid} to the IF/ID pipeline register.
- Supports stall from downstream control and branch redirect/flush from the execute/decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, maximum requests in flight plus buffered instructions (power of 2, ≥2).
- ADDR_W, 32, instruction address width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_i  in  1  downstream cannot accept; hold head instruction.
- branch_flag_i  in  1  redirect fetch and flush all in-flight/buffered instructions.
- branch_target_i  in  ADDR_W  redirect address.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address, word-aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid; one per grant, in order.
- imem_rdata  in  INST_W  returned instruction.
- if_pc  out  ADDR_W  PC of head instruction.
- if_inst  out  INST_W  head instruction.
- if_valid  out  1  head instruction is valid.

Behaviour:
- Reset values (async, rst==0):
  - fetch_pc=RESET_PC.
  - imem_req=0.
  - if_valid=0, if_pc=0, if_inst=0.
  - Outstanding counter=0, discard counter=0, buffer empty.
- Credit rule: imem_req=1 iff out of reset, (outstanding+buffer_count)<DEPTH, and branch_flag_i==0.
  - imem_addr=fetch_pc; both are combinational from state.
- Grant (imem_req&&imem_gnt):
  - fetch_pc+=4, wrap modulo 2^ADDR_W.
  - Outstanding+1; the address is pushed to a pending-PC queue.
- Response (imem_rvalid):
  - If discard>0: discard-1 and drop the data.
  - Otherwise pop the pending PC and push {pc, rdata} into the instruction buffer.
  - Outstanding-1 in either case.
- Grant and response in the same cycle: outstanding is unchanged.
- Output:
  - if_valid = buffer not empty.
  - if_pc/if_inst = buffer head; 0 when empty.
  - Head is popped at the clock edge when if_valid && !stall_i.
  - stall_i holds head stable and continues fetching until credits are exhausted.
- Minimum latency: grant in cycle N, rvalid at N+1, if_valid at N+2.
- Flush (branch_flag_i==1):
  - fetch_pc<=branch_target_i with bits [1:0] forced to 00; instruction buffer and pending-PC queue cleared.
  - discard<=outstanding after this cycle's response is accounted for. An rvalid in the flush cycle is dropped.
  - No request is issued in the flush cycle; the first request to the target is issued the following cycle.
  - Flush overrides stall and pop.
- Back-to-back flushes: the discard count accumulates correctly; the latest target wins.
- No response is ever accepted without a matching outstanding request. An rvalid with outstanding==0 is ignored; flag it in simulation with an assertion.
- Counters are sized log2(DEPTH)+1 bits; they cannot overflow given the credit rule.
- Reset mid-operation: all state returns to reset values immediately. Responses arriving after reset release are ignored by the outstanding==0 rule.

Optional Feature:
- Macro IF_FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0, wrapping at 2^32.
  - perf_fetch_cnt increments on each pop.
  - perf_stall_cnt increments each cycle with if_valid&&stall_i.
- Undefined: neither the ports nor the logic exist.

Decomposition:
- Shared defines file holds:
  - InstAddrBus and InstBus widths.
  - RstEnable redefined as 1'b0 for this active-low reset.
  - Default RESET_PC.
  - NOP encoding constant.
- One sub-module, fetch_fifo: synchronous FIFO, parameterised width/depth, with push/pop/flush/count. It is instantiated twice: once as the pending-PC queue and once as the instruction buffer.

Test Plan:
- Reset release, gnt=1 always, rvalid 1 cycle after grant, stall_i=0 → imem_addr 0,4,8…; if_pc 0,4,8 on consecutive cycles from cycle 2; if_inst matches memory.
- stall_i=1 for 5 cycles with memory ready → exactly DEPTH=2 requests outstanding/buffered, then imem_req=0; if_pc stays 0.
- stall_i released → 0, 4, 8 delivered in order with no gaps.
- branch_flag_i=1 with target 0x103 while 2 requests are in flight → both late responses are dropped; next imem_addr=0x100; first if_pc after flush=0x100.
- rvalid and branch_flag_i in the same cycle → that instruction never appears on if_inst.
- Random gnt/rvalid delays (0–3 cycles) for 1000 instructions → if_pc sequence is strictly +4 between branches; no duplicates or drops.
- rst asserted mid-stream with 2 outstanding → outputs 0 immediately; after release, fetching restarts at RESET_PC; stale rvalids are ignored.
